// File: rtl/graph_pkg.sv
// Shared display-geometry constants and the column evaluator FSM state encoding.
package graph_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned COEF_W   = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STEP  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/poly_mac.sv
// Combinational signed multiply-add: sum_c = acc * x + addend.
// POLY_SAT_EN: when defined, the result saturates from the full-width sum;
// otherwise it wraps to W bits.
module poly_mac #(
  parameter int unsigned W = 32
) (
  input  logic signed [W-1:0] acc,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] addend,
  output logic signed [W-1:0] sum_c
);

`ifdef POLY_SAT_EN
  localparam int unsigned FW = 2 * W + 1;

  logic signed [2*W-1:0] prod;
  logic signed [FW-1:0]  full;

  // Full-precision product plus addend, clamped to the signed W-bit range.
  always_comb begin
    prod = acc * x;
    full = FW'(prod) + FW'(addend);
    if (full[FW-1:W-1] == {(W+2){full[FW-1]}}) begin
      sum_c = full[W-1:0];
    end else if (full[FW-1]) begin
      sum_c = {1'b1, {(W-1){1'b0}}};
    end else begin
      sum_c = {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // Two's complement wrap: everything evaluated in a W-bit context.
  always_comb begin
    sum_c = acc * x + addend;
  end
`endif

endmodule

// File: rtl/poly_column_eval.sv
// Evaluates p(x) = a4 x^4 + ... + a0 by Horner's rule for every screen column
// (x = col - shift_x), writing one result per column every 6 cycles.
// POLY_SAT_EN: saturating arithmetic in poly_mac; timing is unchanged.
module poly_column_eval #(
  parameter int unsigned H_ACTIVE = graph_pkg::H_ACTIVE,
  parameter int unsigned COEF_W   = graph_pkg::COEF_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [COEF_W-1:0] coef0,
  input  logic signed [COEF_W-1:0] coef1,
  input  logic signed [COEF_W-1:0] coef2,
  input  logic signed [COEF_W-1:0] coef3,
  input  logic signed [COEF_W-1:0] coef4,
  input  logic signed [11:0]       shift_x,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_en,
  output logic [9:0]               wr_addr,
  output logic signed [COEF_W-1:0] wr_data
);

  import graph_pkg::*;

  localparam int unsigned COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  state_t                   state;
  state_t                   next;
  logic [COL_W-1:0]         col;
  logic signed [COEF_W-1:0] coef_sh [5];
  logic signed [11:0]       shift_sh;
  logic signed [COEF_W-1:0] acc;
  logic signed [COEF_W-1:0] x;
  logic [1:0]               k;
  logic signed [COEF_W-1:0] mac_sum;
  logic signed [COEF_W-1:0] col_ext;
  logic signed [COEF_W-1:0] shift_ext;
  logic                     last_col;

  assign last_col  = (col == COL_W'(H_ACTIVE - 1));
  assign col_ext   = COEF_W'($signed({1'b0, col}));
  assign shift_ext = COEF_W'(shift_sh);

  poly_mac #(.W(COEF_W)) u_mac (
    .acc    (acc),
    .x      (x),
    .addend (coef_sh[{1'b0, k}]),
    .sum_c  (mac_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  // Next-state logic.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = LOAD;
      LOAD:    next = STEP;
      STEP:    if (k == 2'd0) next = WRITE;
      WRITE:   next = last_col ? FIN : LOAD;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Shadow operands, column counter and Horner accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col      <= '0;
      acc      <= '0;
      x        <= '0;
      k        <= '0;
      shift_sh <= '0;
      for (int i = 0; i < 5; i++) coef_sh[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            coef_sh[0] <= coef0;
            coef_sh[1] <= coef1;
            coef_sh[2] <= coef2;
            coef_sh[3] <= coef3;
            coef_sh[4] <= coef4;
            shift_sh   <= shift_x;
            col        <= '0;
          end
        end
        LOAD: begin
          acc <= coef_sh[4];
          x   <= col_ext - shift_ext;
          k   <= 2'd3;
        end
        STEP: begin
          acc <= mac_sum;
          k   <= k - 2'd1;
        end
        WRITE: begin
          if (!last_col) col <= col + COL_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered status and column-buffer write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      busy  <= (next != IDLE);
      done  <= (state == FIN);
      wr_en <= (state == WRITE);
      if (state == WRITE) begin
        wr_addr <= 10'(col);
        wr_data <= acc;
      end
    end
  end

endmodule

// File: tb/tb_poly_column_eval.sv
// Scoreboard bench for poly_column_eval at default parameters.
module tb_poly_column_eval;

  localparam int H = 800;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [31:0] coef0, coef1, coef2, coef3, coef4;
  logic signed [11:0] shift_x;
  logic               busy, done, wr_en;
  logic [9:0]         wr_addr;
  logic signed [31:0] wr_data;

  poly_column_eval dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .coef0   (coef0),
    .coef1   (coef1),
    .coef2   (coef2),
    .coef3   (coef3),
    .coef4   (coef4),
    .shift_x (shift_x),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_wr = 0;
  bit   first_wr = 1'b0;
  int   done_cnt = 0;
  int   got [H];
  exp_t q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference value of the polynomial at screen x, Horner per step.
  function automatic int model(int a0, int a1, int a2, int a3, int a4, int xv);
    longint acc;
    int c [4];
    c[0] = a0; c[1] = a1; c[2] = a2; c[3] = a3;
    acc = a4;
    for (int k = 3; k >= 0; k--) begin
      acc = acc * xv + c[k];
`ifdef POLY_SAT_EN
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
      acc = longint'(int'(acc));
`endif
    end
    return int'(acc);
  endfunction

  // Output monitor: pops the scoreboard on each write and checks cadence.
  always @(negedge clk) begin
    if (wr_en) begin
      if (q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
      if (int'(wr_addr) < H) got[wr_addr] = wr_data;
      check("wr_time", cyc, first_wr ? start_cyc + 6 : last_wr + 6);
      check("busy_during_run", busy, 1);
      last_wr  = cyc;
      first_wr = 1'b0;
    end
    if (done) begin
      done_cnt++;
      check("done_time", cyc, start_cyc + 6 * H + 1);
    end
  end

  task automatic run_start(input int c0, input int c1, input int c2,
                           input int c3, input int c4, input int sh);
    for (int i = 0; i < H; i++) got[i] = -12345;
    for (int col = 0; col < H; col++) begin
      exp_t e;
      e.addr = col;
      e.data = model(c0, c1, c2, c3, c4, col - sh);
      q.push_back(e);
    end
    @(negedge clk);
    coef0 = 32'(c0); coef1 = 32'(c1); coef2 = 32'(c2);
    coef3 = 32'(c3); coef4 = 32'(c4);
    shift_x   = 12'(sh);
    start     = 1'b1;
    start_cyc = cyc + 1;
    first_wr  = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 6 * H + 100) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", done_cnt, d0 + 1);
    check("queue_drained", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int n;
    reset = 1'b0; start = 1'b0;
    coef0 = '0; coef1 = '0; coef2 = '0; coef3 = '0; coef4 = '0;
    shift_x = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Constant polynomial.
    d0 = done_cnt;
    run_start(7, 0, 0, 0, 0, 0);
    check("busy_after_start", busy, 1);
    wait_done(d0);
    check("const_first", got[0], 7);
    check("const_last", got[H-1], 7);
    check("idle_busy", busy, 0);

    // Parabola centred on column 400.
    d0 = done_cnt;
    run_start(0, 0, 1, 0, 0, 400);
    wait_done(d0);
    check("sq_addr0", got[0], 160000);
    check("sq_addr400", got[400], 0);
    check("sq_addr401", got[401], 1);
    check("sq_addr799", got[799], 159201);

    // Start re-pulsed and inputs changed mid-run are ignored.
    d0 = done_cnt;
    run_start(3, -2, 1, 0, 0, 100);
    repeat (99) @(negedge clk);
    start = 1'b1;
    coef0 = 32'sd99; coef2 = -32'sd5; coef4 = 32'sd1; shift_x = 12'sd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0);
    repeat (30) @(posedge clk);
    check("single_done", done_cnt, d0 + 1);
    check("no_restart", q.size(), 0);

    // Reset in the middle of a run.
    d0 = done_cnt;
    run_start(0, 5, 0, 0, 0, 0);
    n = 0;
    while (!(wr_en && wr_addr == 10'd100) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_col100", wr_addr, 100);
    reset = 1'b0;
    @(negedge clk);
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_wr_addr", wr_addr, 0);
    q.delete();
    reset = 1'b1;
    repeat (20) @(posedge clk);
    check("abort_no_done", done_cnt, d0);
    @(negedge clk);
    run_start(0, 5, 0, 0, 0, 0);
    wait_done(d0);
    check("restart_addr0", got[0], 0);
    check("restart_addr799", got[799], 3995);

    // Large quartic at the last column.
    d0 = done_cnt;
    run_start(0, 0, 0, 0, 1000, 0);
    wait_done(d0);
`ifdef POLY_SAT_EN
    check("quartic_799", got[799], 2147483647);
`else
    check("quartic_799", got[799], 2095116264);
`endif
    check("quartic_1", got[1], 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_column_eval.md
POLY_COLUMN_EVAL -- requirements
Module: poly_column_eval

Interface
REQ-001 Parameter H_ACTIVE, default 800: number of screen columns evaluated per run.
REQ-002 Parameter COEF_W, default 32: signed coefficient and result width.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  run request, sampled each cycle.
REQ-006 coef0..coef4  input  COEF_W each  signed polynomial coefficients a0..a4.
REQ-007 shift_x  input  12  signed column of the origin (screen x = col - shift_x).
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse when a run completes.
REQ-010 wr_en  output  1  column-buffer write strobe.
REQ-011 wr_addr  output  10  column index 0..H_ACTIVE-1.
REQ-012 wr_data  output  COEF_W  signed p(x) for that column.

Function
REQ-013 The block SHALL use FSM states IDLE, LOAD, STEP, WRITE and FIN.
REQ-014 In IDLE with start high, it SHALL latch coef0..coef4 and shift_x into shadow registers, clear col to 0 and enter LOAD.
REQ-015 start SHALL be ignored in every state except IDLE; input changes during a run SHALL NOT affect that run.
REQ-016 LOAD SHALL set acc = a4, x = col - shift_x (sign-extended to COEF_W) and k = 3.
REQ-017 STEP SHALL run 4 cycles, k = 3,2,1,0, each computing acc = acc*x + a_k, then go to WRITE.
REQ-018 WRITE SHALL assert wr_en for exactly one cycle with wr_addr = col and wr_data = acc.
REQ-019 After WRITE: if col = H_ACTIVE-1 go to FIN, else col+1 and LOAD.
REQ-020 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-021 Column period SHALL be 6 cycles; first wr_en 6 cycles after the start-sampling edge; done 6*H_ACTIVE+1 cycles after it (4801 at default).
REQ-022 Without the Configuration macro, each STEP result SHALL wrap modulo 2^COEF_W (two's complement truncation).
REQ-023 wr_en SHALL be low in every state except WRITE; wr_addr and wr_data SHALL hold their last values otherwise.

Reset
REQ-024 reset low SHALL force IDLE, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, col=0, acc=0 on the next edge.
REQ-025 Reset mid-run SHALL abort without a done pulse; the next start SHALL restart from column 0.

Configuration
REQ-026 With POLY_SAT_EN defined, each STEP result SHALL saturate to [-2^(COEF_W-1), 2^(COEF_W-1)-1] from a full 2*COEF_W-bit product plus addend.
REQ-027 Without POLY_SAT_EN, the REQ-022 wrap SHALL apply and no saturation logic SHALL be present; timing is identical in both builds.

Structure
REQ-028 Shared package graph_pkg SHALL hold H_ACTIVE, V_ACTIVE, COEF_W and the FSM state enum.
REQ-029 Sub-module poly_mac SHALL implement the combinational signed multiply-add, with optional saturation under POLY_SAT_EN.

Verification
REQ-030 a0=7, others 0, shift_x=0, start -> 800 writes, addr 0..799, all data 7; done at cycle 4801.
REQ-031 a2=1, others 0, shift_x=400 -> addr 0 data 160000, addr 400 data 0, addr 401 data 1, addr 799 data 159201.
REQ-032 start re-pulsed at cycle 100 and coefficients changed mid-run -> no restart, outputs from the original coefficients, a single done.
REQ-033 reset low at col 100 -> wr_en=0 and busy=0 next cycle, no done; a new start writes addr 0 first.
REQ-034 a4=1000, shift_x=0, col 799 -> with POLY_SAT_EN data 2147483647; without it data = (1000*799^4) mod 2^32 as signed.
REQ-035 Timing check: wr_en pulses exactly every 6 cycles, first at start+6, and busy stays high throughout the run.
